// File: rtl/cmd_encoder.sv
// ---------------------------------------------------------------------------
// cmd_encoder
//
// Front-panel command encoder for the stopwatch. Each of the three raw push
// buttons is brought into the clk domain through a two-flop synchronizer and
// debounced. The rising edge of the debounced level is a press event. A small
// mode FSM turns press events into the held 3-bit command level consumed by
// the time manager:
//     000 idle, 001 start (run), 010 stop (halt), 100 reset (clear)
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive cycles a synchronized button must hold a
//                     new level before it is accepted (>= 1)
//   RESET_HOLD      : cycles operation stays at 100 after a reset press (>= 1)
//
// Ports
//   clk        in   system clock
//   rst_b      in   asynchronous, active-low reset
//   btn_start  in   raw start button, active-high, asynchronous to clk
//   btn_stop   in   raw stop button, active-high, asynchronous to clk
//   btn_reset  in   raw reset button, active-high, asynchronous to clk
//   operation  out  registered command level (held, not a pulse)
//   cmd_valid  out  one-cycle pulse on the first cycle operation shows the
//                   state entered by an accepted press
//   busy       out  high while clearing; presses are dropped meanwhile
// ---------------------------------------------------------------------------
module cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESET_HOLD      = 4
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_reset,
    output logic [2:0] operation,
    output logic       cmd_valid,
    output logic       busy
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    // The counter compares against N-1 because the edge that would bring it
    // to N is the same edge on which the new level is taken.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    localparam logic [2:0] OP_IDLE  = 3'b000;
    localparam logic [2:0] OP_RUN   = 3'b001;
    localparam logic [2:0] OP_HALT  = 3'b010;
    localparam logic [2:0] OP_CLEAR = 3'b100;

    // Button index: 0 start, 1 stop, 2 reset.
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_RESET = 2;

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_reset, btn_stop, btn_start};

    // -----------------------------------------------------------------------
    // Per-button synchronizer + debouncer + rising-edge detect
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_prev_reg;
            logic [DEB_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    deb_reg      <= 1'b0;
                    deb_prev_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= btn_raw[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        // Any sample matching the accepted level restarts
                        // the qualification window.
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            // Only the debounced rise is an event; releases are silent.
            assign press[gi] = deb_reg & ~deb_prev_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Priority select: reset > stop > start. At most one of these is high,
    // so a lower-priority press arriving with a higher one is simply lost.
    // -----------------------------------------------------------------------
    logic sel_reset;
    logic sel_stop;
    logic sel_start;

    assign sel_reset = press[BTN_RESET];
    assign sel_stop  = press[BTN_STOP]  & ~press[BTN_RESET];
    assign sel_start = press[BTN_START] & ~press[BTN_STOP] & ~press[BTN_RESET];

    // -----------------------------------------------------------------------
    // Mode FSM with registered outputs
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT,
        ST_CLEAR
    } state_t;

    state_t              state_reg;
    logic [2:0]          operation_reg;
    logic                cmd_valid_reg;
    logic                busy_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg     <= ST_IDLE;
            operation_reg <= OP_IDLE;
            cmd_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            hold_cnt_reg  <= '0;
        end else begin
            cmd_valid_reg <= 1'b0;
            case (state_reg)
                // IDLE and HALT react identically: start resumes, stop is
                // a no-op, reset clears.
                ST_IDLE, ST_HALT: begin
                    if (sel_reset) begin
                        state_reg     <= ST_CLEAR;
                        operation_reg <= OP_CLEAR;
                        busy_reg      <= 1'b1;
                        hold_cnt_reg  <= '0;
                        cmd_valid_reg <= 1'b1;
                    end else if (sel_start) begin
                        state_reg     <= ST_RUN;
                        operation_reg <= OP_RUN;
                        cmd_valid_reg <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (sel_reset) begin
                        state_reg     <= ST_CLEAR;
                        operation_reg <= OP_CLEAR;
                        busy_reg      <= 1'b1;
                        hold_cnt_reg  <= '0;
                        cmd_valid_reg <= 1'b1;
                    end else if (sel_stop) begin
                        state_reg     <= ST_HALT;
                        operation_reg <= OP_HALT;
                        cmd_valid_reg <= 1'b1;
                    end
                end

                // Every press event seen here is consumed and dropped,
                // including one coinciding with the exit edge.
                ST_CLEAR: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg     <= ST_IDLE;
                        operation_reg <= OP_IDLE;
                        busy_reg      <= 1'b0;
                        hold_cnt_reg  <= '0;
                    end else begin
                        hold_cnt_reg  <= hold_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    operation_reg <= OP_IDLE;
                    busy_reg      <= 1'b0;
                    hold_cnt_reg  <= '0;
                end
            endcase
        end
    end

    assign operation = operation_reg;
    assign cmd_valid = cmd_valid_reg;
    assign busy      = busy_reg;

endmodule
